// File: rtl/counter_pkg.sv
// Shared definitions for the run/stop/lap/clear event-counter sequencer.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  // 100 Hz tick and 20 ms debounce at a 50 MHz clock
  localparam int unsigned DIV_DEFAULT        = 500000;
  localparam int unsigned DEB_CYCLES_DEFAULT = 1000000;

  // States in which the BCD counter is advancing
  function automatic logic is_counting(state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton path: two-flop synchronizer, stability debounce, and a
// one-cycle press event on the falling edge of the accepted level.
module key_debounce
  import counter_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  // Counter only needs to reach DEB_CYCLES-1; acceptance happens on that cycle
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             acc_q, acc_d;
  logic             acc_dly_q, acc_dly_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

  // Synchronize, count stable cycles of a differing level, detect accepted falling edge
  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    acc_d     = acc_q;
    deb_cnt_d = '0;
    if (sync2_q != acc_q) begin
      if (deb_cnt_q == CNT_LAST) begin
        acc_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    acc_dly_d = acc_q;
    press_d   = acc_dly_q & ~acc_q;
  end

  // Released (high) is the idle level of every key stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      acc_q     <= 1'b1;
      acc_dly_q <= 1'b1;
      press_q   <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      acc_q     <= acc_d;
      acc_dly_q <= acc_dly_d;
      press_q   <= press_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/counter_ctrl.sv
// Run/stop/lap/clear sequencer for the four-digit BCD event counter.
//
//   state | meaning
//   ------+-------------------------------------------------------
//   IDLE  | stopped, prescaler held at 0, clear allowed
//   RUN   | counting, display live
//   LAP   | counting, display frozen (disp_hold)
//   PAUSE | stopped, prescaler keeps its partial period
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned DIV        = DIV_DEFAULT,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start_n,
  input  logic       key_stop_n,
  input  logic       key_lap_n,
  input  logic       key_clear_n,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic [1:0] state
);

  localparam int unsigned PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic ev_start, ev_stop, ev_lap, ev_clear;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             cnt_clr_q, cnt_clr_d;
  logic             cnt_en_c;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_start (
    .clk(clk), .rst(rst), .key_n(key_start_n), .press(ev_start)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_stop (
    .clk(clk), .rst(rst), .key_n(key_stop_n), .press(ev_stop)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_lap (
    .clk(clk), .rst(rst), .key_n(key_lap_n), .press(ev_lap)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_clear (
    .clk(clk), .rst(rst), .key_n(key_clear_n), .press(ev_clear)
  );

  // Next state from the single highest-priority event, then prescaler and tick
  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    pre_d     = pre_q;
    cnt_en_c  = 1'b0;

    if (ev_clear) begin
      state_d   = ST_IDLE;
      cnt_clr_d = 1'b1;
    end else if (ev_stop) begin
      if (is_counting(state_q)) state_d = ST_PAUSE;
    end else if (ev_start) begin
      if ((state_q == ST_IDLE) || (state_q == ST_PAUSE)) state_d = ST_RUN;
    end else if (ev_lap) begin
      case (state_q)
        ST_RUN:  state_d = ST_LAP;
        ST_LAP:  state_d = ST_RUN;
        default: state_d = state_q;
      endcase
    end

    // A tick is only issued (and the period only wraps) when counting
    // continues past this edge; otherwise DIV-1 is held so a resume ticks at once.
    if (state_q == ST_IDLE) begin
      pre_d = '0;
    end else if (is_counting(state_q)) begin
      if (pre_q == PRE_LAST) begin
        if (is_counting(state_d)) begin
          pre_d    = '0;
          cnt_en_c = 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // State, prescaler and registered clear pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  assign cnt_en    = cnt_en_c;
  assign cnt_clr   = cnt_clr_q;
  assign disp_hold = (state_q == ST_LAP);
  assign state     = state_q;

endmodule
